// File: rtl/riio_ibias_ctrl.sv
// Power-up sequencer for the EG1D80V bias/bandgap IO cell: startup pulse, wait for
// a synchronized valid flag, settle, then report ready; latches a sticky fault.
module riio_ibias_ctrl #(
  parameter int STARTUP_CYCLES = 16,
  parameter int SETTLE_CYCLES  = 64,
  parameter int TIMEOUT_CYCLES = 256,
  parameter int CNT_W          = 9
) (
  input  logic       CLK_I,
  input  logic       RST_I,
  input  logic       IBIAS_REQ_I,
  input  logic       VBIAS_REQ_I,
  input  logic [4:0] TRIM_IBIAS_CFG_I,
  input  logic [3:0] TRIM_VBIAS_CFG_I,
  input  logic       TRIM_LOAD_I,
  input  logic       FAULT_CLR_I,
  input  logic       BG_VALID_I,
  output logic       EN_IBIAS_O,
  output logic       EN_VBIAS_O,
  output logic       BG_STARTUP_O,
  output logic [4:0] TRIM_IBIAS_O,
  output logic [3:0] TRIM_VBIAS_O,
  output logic       READY_O,
  output logic       FAULT_O,
  output logic [2:0] STATE_O
);

  typedef enum logic [2:0] {
    OFF        = 3'd0,
    STARTUP    = 3'd1,
    WAIT_VALID = 3'd2,
    SETTLE     = 3'd3,
    READY      = 3'd4,
    FAULT      = 3'd5
  } stateT;

  localparam logic [CNT_W-1:0] START_LOAD   = CNT_W'(STARTUP_CYCLES - 1);
  localparam logic [CNT_W-1:0] SETTLE_LOAD  = CNT_W'(SETTLE_CYCLES - 1);
  localparam logic [CNT_W-1:0] TIMEOUT_LOAD = CNT_W'(TIMEOUT_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_ONE      = CNT_W'(1);

  stateT            state;
  logic [CNT_W-1:0] cnt;
  logic [1:0]       validSync;
  logic             enI, enV, startup, readyR, faultR;
  logic [4:0]       trimI;
  logic [3:0]       trimV;

  logic vs, anyReq, addCh, dropCh;

  assign vs     = validSync[1];
  assign anyReq = IBIAS_REQ_I | VBIAS_REQ_I;
  // A channel newly requested needs the full startup; a channel released just turns off.
  assign addCh  = (IBIAS_REQ_I & ~enI) | (VBIAS_REQ_I & ~enV);
  assign dropCh = (~IBIAS_REQ_I & enI) | (~VBIAS_REQ_I & enV);

  always_ff @(posedge CLK_I or posedge RST_I) begin
    if (RST_I) begin
      state     <= OFF;
      cnt       <= '0;
      validSync <= 2'b00;
      enI       <= 1'b0;
      enV       <= 1'b0;
      startup   <= 1'b0;
      readyR    <= 1'b0;
      faultR    <= 1'b0;
      trimI     <= '0;
      trimV     <= '0;
    end else begin
      validSync <= {validSync[0], BG_VALID_I};
      if (cnt != '0) cnt <= cnt - CNT_ONE;
      case (state)
        OFF: begin
          if (anyReq) begin
            enI     <= IBIAS_REQ_I;
            enV     <= VBIAS_REQ_I;
            trimI   <= TRIM_IBIAS_CFG_I;
            trimV   <= TRIM_VBIAS_CFG_I;
            cnt     <= START_LOAD;
            startup <= 1'b1;
            state   <= STARTUP;
          end
        end
        STARTUP: begin
          if (!anyReq) begin
            state <= OFF; enI <= 1'b0; enV <= 1'b0; startup <= 1'b0; cnt <= '0;
          end else if (cnt == '0) begin
            cnt     <= TIMEOUT_LOAD;
            startup <= 1'b0;
            state   <= WAIT_VALID;
          end
        end
        WAIT_VALID: begin
          if (!anyReq) begin
            state <= OFF; enI <= 1'b0; enV <= 1'b0; cnt <= '0;
          end else if (vs) begin
            cnt   <= SETTLE_LOAD;
            state <= SETTLE;
          end else if (cnt == '0) begin
            state <= FAULT; enI <= 1'b0; enV <= 1'b0; faultR <= 1'b1;
          end
        end
        SETTLE: begin
          if (!vs) begin
            state <= FAULT; enI <= 1'b0; enV <= 1'b0; faultR <= 1'b1; cnt <= '0;
          end else if (!anyReq) begin
            state <= OFF; enI <= 1'b0; enV <= 1'b0; cnt <= '0;
          end else if (cnt == '0) begin
            readyR <= 1'b1;
            state  <= READY;
          end
        end
        READY: begin
          if (!vs) begin
            state <= FAULT; enI <= 1'b0; enV <= 1'b0; readyR <= 1'b0; faultR <= 1'b1;
          end else if (!anyReq) begin
            state <= OFF; enI <= 1'b0; enV <= 1'b0; readyR <= 1'b0;
          end else if (addCh) begin
            enI     <= IBIAS_REQ_I;
            enV     <= VBIAS_REQ_I;
            trimI   <= TRIM_IBIAS_CFG_I;
            trimV   <= TRIM_VBIAS_CFG_I;
            cnt     <= START_LOAD;
            startup <= 1'b1;
            readyR  <= 1'b0;
            state   <= STARTUP;
          end else if (dropCh) begin
            enI <= enI & IBIAS_REQ_I;
            enV <= enV & VBIAS_REQ_I;
          end else if (TRIM_LOAD_I) begin
            trimI  <= TRIM_IBIAS_CFG_I;
            trimV  <= TRIM_VBIAS_CFG_I;
            cnt    <= SETTLE_LOAD;
            readyR <= 1'b0;
            state  <= SETTLE;
          end
        end
        FAULT: begin
          // Requests are ignored here; a clear returns to OFF, which re-evaluates them.
          if (FAULT_CLR_I) begin
            faultR <= 1'b0;
            state  <= OFF;
          end
        end
        default: begin
          state <= OFF; enI <= 1'b0; enV <= 1'b0; startup <= 1'b0;
          readyR <= 1'b0; faultR <= 1'b0; cnt <= '0;
        end
      endcase
    end
  end

  assign EN_IBIAS_O   = enI;
  assign EN_VBIAS_O   = enV;
  assign BG_STARTUP_O = startup;
  assign TRIM_IBIAS_O = trimI;
  assign TRIM_VBIAS_O = trimV;
  assign READY_O      = readyR;
  assign FAULT_O      = faultR;
  assign STATE_O      = state;

endmodule

// File: tb/tb_riio_ibias_ctrl.sv
// Directed bench for riio_ibias_ctrl: power-up, channel add/remove, trim reload,
// valid loss, timeout, abort and asynchronous reset.
module tb_riio_ibias_ctrl;

  logic       CLK_I = 1'b0;
  logic       RST_I = 1'b1;
  logic       IBIAS_REQ_I = 1'b0;
  logic       VBIAS_REQ_I = 1'b0;
  logic [4:0] TRIM_IBIAS_CFG_I = '0;
  logic [3:0] TRIM_VBIAS_CFG_I = '0;
  logic       TRIM_LOAD_I = 1'b0;
  logic       FAULT_CLR_I = 1'b0;
  logic       BG_VALID_I = 1'b0;
  logic       EN_IBIAS_O, EN_VBIAS_O, BG_STARTUP_O, READY_O, FAULT_O;
  logic [4:0] TRIM_IBIAS_O;
  logic [3:0] TRIM_VBIAS_O;
  logic [2:0] STATE_O;

  int nAsserts = 0;
  int nFail = 0;
  int n;

  riio_ibias_ctrl dut (
    .CLK_I(CLK_I), .RST_I(RST_I),
    .IBIAS_REQ_I(IBIAS_REQ_I), .VBIAS_REQ_I(VBIAS_REQ_I),
    .TRIM_IBIAS_CFG_I(TRIM_IBIAS_CFG_I), .TRIM_VBIAS_CFG_I(TRIM_VBIAS_CFG_I),
    .TRIM_LOAD_I(TRIM_LOAD_I), .FAULT_CLR_I(FAULT_CLR_I), .BG_VALID_I(BG_VALID_I),
    .EN_IBIAS_O(EN_IBIAS_O), .EN_VBIAS_O(EN_VBIAS_O), .BG_STARTUP_O(BG_STARTUP_O),
    .TRIM_IBIAS_O(TRIM_IBIAS_O), .TRIM_VBIAS_O(TRIM_VBIAS_O),
    .READY_O(READY_O), .FAULT_O(FAULT_O), .STATE_O(STATE_O)
  );

  always #5 CLK_I = ~CLK_I;

  // Inputs change and outputs are sampled on the falling edge.
  task automatic cyc(input int k);
    repeat (k) @(negedge CLK_I);
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] want);
    nAsserts++;
    assert (obs === want) else begin
      nFail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, want);
    end
  endtask

  initial begin
    // Reset state
    cyc(2);
    chk("rst_state", 32'(STATE_O), 0);
    chk("rst_flags", 32'({EN_IBIAS_O, EN_VBIAS_O, BG_STARTUP_O, READY_O, FAULT_O}), 0);
    chk("rst_trims", 32'({TRIM_IBIAS_O, TRIM_VBIAS_O}), 0);
    RST_I = 1'b0;
    cyc(1);
    chk("idle_state", 32'(STATE_O), 0);

    // Power-up on IBIAS only
    IBIAS_REQ_I = 1'b1; TRIM_IBIAS_CFG_I = 5'h0A; TRIM_VBIAS_CFG_I = 4'h3;
    cyc(1);
    chk("pu_state", 32'(STATE_O), 1);
    chk("pu_startup", 32'(BG_STARTUP_O), 1);
    chk("pu_en_i", 32'(EN_IBIAS_O), 1);
    chk("pu_en_v", 32'(EN_VBIAS_O), 0);
    chk("pu_trim_i", 32'(TRIM_IBIAS_O), 32'h0A);
    n = 0;
    while (BG_STARTUP_O === 1'b1 && n < 40) begin n++; cyc(1); end
    chk("pu_startup_len", 32'(n), 16);
    chk("pu_wait_state", 32'(STATE_O), 2);
    cyc(2);
    BG_VALID_I = 1'b1;
    cyc(3);
    chk("pu_settle_state", 32'(STATE_O), 3);
    cyc(63);
    chk("pu_not_ready_yet", 32'(READY_O), 0);
    cyc(1);
    chk("pu_ready", 32'(READY_O), 1);
    chk("pu_ready_state", 32'(STATE_O), 4);
    chk("pu_en_v_off", 32'(EN_VBIAS_O), 0);

    // Add VBIAS channel: full re-sequence
    VBIAS_REQ_I = 1'b1;
    cyc(1);
    chk("add_state", 32'(STATE_O), 1);
    chk("add_ready_low", 32'(READY_O), 0);
    chk("add_en", 32'({EN_IBIAS_O, EN_VBIAS_O}), 32'b11);
    n = 0;
    while (BG_STARTUP_O === 1'b1 && n < 40) begin n++; cyc(1); end
    chk("add_startup_len", 32'(n), 16);
    cyc(1);
    chk("add_settle_state", 32'(STATE_O), 3);
    cyc(63);
    chk("add_not_ready_yet", 32'(READY_O), 0);
    cyc(1);
    chk("add_ready", 32'(READY_O), 1);

    // Drop IBIAS channel
    IBIAS_REQ_I = 1'b0;
    cyc(1);
    chk("drop_en", 32'({EN_IBIAS_O, EN_VBIAS_O}), 32'b01);
    chk("drop_ready", 32'(READY_O), 1);
    chk("drop_state", 32'(STATE_O), 4);

    // Trim reload
    TRIM_VBIAS_CFG_I = 4'h7; TRIM_LOAD_I = 1'b1;
    cyc(1);
    TRIM_LOAD_I = 1'b0;
    chk("trim_v_load", 32'(TRIM_VBIAS_O), 32'h7);
    chk("trim_i_load", 32'(TRIM_IBIAS_O), 32'h0A);
    chk("trim_state", 32'(STATE_O), 3);
    n = 0;
    while (READY_O !== 1'b1 && n < 100) begin n++; cyc(1); end
    chk("trim_settle_len", 32'(n), 64);
    chk("trim_ready_state", 32'(STATE_O), 4);
    TRIM_IBIAS_CFG_I = 5'h1F; TRIM_VBIAS_CFG_I = 4'h0;
    cyc(3);
    chk("cfg_no_load", 32'({TRIM_IBIAS_O, TRIM_VBIAS_O}), 32'({5'h0A, 4'h7}));

    // One-cycle valid glitch in READY
    BG_VALID_I = 1'b0;
    cyc(1);
    BG_VALID_I = 1'b1;
    cyc(2);
    chk("vloss_state", 32'(STATE_O), 5);
    chk("vloss_flags", 32'({EN_IBIAS_O, EN_VBIAS_O, READY_O, FAULT_O}), 32'b0001);
    cyc(5);
    chk("vloss_sticky", 32'(FAULT_O), 1);
    chk("vloss_trim_hold", 32'(TRIM_VBIAS_O), 32'h7);

    // Clear fault with VBIAS still requested: OFF, then restart
    FAULT_CLR_I = 1'b1;
    cyc(1);
    FAULT_CLR_I = 1'b0;
    chk("clr_state", 32'(STATE_O), 0);
    chk("clr_fault", 32'(FAULT_O), 0);
    cyc(1);
    chk("clr_restart", 32'(STATE_O), 1);
    chk("clr_en", 32'({EN_IBIAS_O, EN_VBIAS_O}), 32'b01);

    // Abort mid-STARTUP
    cyc(4);
    chk("abort_pre", 32'(BG_STARTUP_O), 1);
    VBIAS_REQ_I = 1'b0;
    cyc(1);
    chk("abort_state", 32'(STATE_O), 0);
    chk("abort_flags", 32'({EN_IBIAS_O, EN_VBIAS_O, BG_STARTUP_O}), 0);

    // Timeout with valid stuck low
    BG_VALID_I = 1'b0; IBIAS_REQ_I = 1'b1; VBIAS_REQ_I = 1'b1;
    TRIM_IBIAS_CFG_I = 5'h15; TRIM_VBIAS_CFG_I = 4'h9;
    cyc(1);
    chk("to_state", 32'(STATE_O), 1);
    chk("to_trims", 32'({TRIM_IBIAS_O, TRIM_VBIAS_O}), 32'({5'h15, 4'h9}));
    cyc(16);
    chk("to_wait", 32'(STATE_O), 2);
    cyc(255);
    chk("to_not_yet", 32'({STATE_O, FAULT_O}), 32'({3'd2, 1'b0}));
    cyc(1);
    chk("to_fault", 32'({STATE_O, FAULT_O}), 32'({3'd5, 1'b1}));
    chk("to_en_off", 32'({EN_IBIAS_O, EN_VBIAS_O}), 0);
    FAULT_CLR_I = 1'b1;
    cyc(1);
    FAULT_CLR_I = 1'b0;
    chk("to_clr_off", 32'(STATE_O), 0);
    cyc(1);
    chk("to_clr_restart", 32'(STATE_O), 1);

    // Asynchronous reset from READY
    BG_VALID_I = 1'b1;
    n = 0;
    while (READY_O !== 1'b1 && n < 200) begin n++; cyc(1); end
    chk("ar_ready", 32'(READY_O), 1);
    #2 RST_I = 1'b1;
    #1;
    chk("ar_flags", 32'({EN_IBIAS_O, EN_VBIAS_O, BG_STARTUP_O, READY_O, FAULT_O}), 0);
    chk("ar_state_trim", 32'({STATE_O, TRIM_IBIAS_O, TRIM_VBIAS_O}), 0);
    IBIAS_REQ_I = 1'b0; VBIAS_REQ_I = 1'b0;
    cyc(1);
    RST_I = 1'b0;
    cyc(1);
    chk("ar_idle", 32'(STATE_O), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", nAsserts, nFail);
    $finish;
  end

endmodule
